// File: rtl/inst_fetch_pkg.sv
// Shared constants for the instruction-fetch slice: widths, enables, FSM encoding, cache geometry.
package inst_fetch_pkg;

    localparam int unsigned AddrLen      = 32;
    localparam int unsigned InstLen      = 32;
    localparam int unsigned ICACHE_IDX_W = 7;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    localparam logic [InstLen-1:0] ZERO_WORD = '0;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] WAIT_MEM = 1'b1;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, synchronous fill.
// Arrays exist only when IF_ICACHE_EN is defined; otherwise lookup always misses and fill is a no-op.
module icache_dm
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrLen,
    parameter int unsigned INST_W = InstLen,
    parameter int unsigned IDX_W  = ICACHE_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [INST_W-1:0] rd_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [INST_W-1:0] fill_data
);

`ifdef IF_ICACHE_EN
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;
    localparam int unsigned LINES = 1 << IDX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [INST_W-1:0] data_q [LINES];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [TAG_W-1:0] wr_tag;
    logic             unused_byte_bits;

    assign rd_idx = lookup_addr[IDX_W+1:2];
    assign rd_tag = lookup_addr[ADDR_W-1:IDX_W+2];
    assign wr_idx = fill_addr[IDX_W+1:2];
    assign wr_tag = fill_addr[ADDR_W-1:IDX_W+2];

    // Instructions are word aligned; the byte offset never takes part in lookup.
    assign unused_byte_bits = ^{lookup_addr[1:0], fill_addr[1:0]};

    assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (rdy && fill_en) begin
            valid_q[wr_idx] <= Enable;
        end
    end

    // Tag and data need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (rst && rdy && fill_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= fill_data;
        end
    end
`else
    logic unused_ports;

    assign hit          = Disable;
    assign rd_data      = '0;
    assign unused_ports = ^{clk, rst, rdy, lookup_addr, fill_en, fill_addr, fill_data};
`endif

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: I-cache lookup, miss handshake to memory, registered IF/ID bundle.
// Build option IF_ICACHE_EN enables the cache arrays; without it every fetch goes to memory.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrLen,
    parameter int unsigned INST_W = InstLen,
    parameter int unsigned IDX_W  = ICACHE_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              stall_i,
    input  logic              pc_enable_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_jump_enable_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_done_i,
    input  logic [INST_W-1:0] mem_data_i,
    output logic              icache_hitted_o,
    output logic              inst_ready_o,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o
);

    logic [0:0]        state_q, state_d;
    logic              discard_q, discard_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              inst_valid_q, inst_valid_d;
    logic              pend_valid_q, pend_valid_d;
    logic [INST_W-1:0] pend_inst_q, pend_inst_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic              cache_hit;
    logic [INST_W-1:0] cache_data;
    logic              fill_en;
    logic              deliver;

    assign fill_en = (state_q == WAIT_MEM) && mem_done_i;
    // A jump in the same cycle as the return discards it just like an earlier jump.
    assign deliver = !discard_q && !pc_jump_enable_i;

    icache_dm #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W),
        .IDX_W (IDX_W)
    ) u_icache (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .lookup_addr(pc_i),
        .hit        (cache_hit),
        .rd_data    (cache_data),
        .fill_en    (fill_en),
        .fill_addr  (mem_addr_q),
        .fill_data  (mem_data_i)
    );

    assign icache_hitted_o = rst && pc_enable_i && (state_q == IDLE) && cache_hit;
    assign inst_ready_o    = rst && rdy && fill_en && deliver;

    always_comb begin
        state_d      = state_q;
        discard_d    = discard_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_valid_d = inst_valid_q;
        pend_valid_d = pend_valid_q;
        pend_inst_d  = pend_inst_q;
        pend_pc_d    = pend_pc_q;

        case (state_q)
            IDLE: begin
                if (pc_jump_enable_i) begin
                    inst_valid_d = Disable;
                    pend_valid_d = Disable;
                end else if (!stall_i) begin
                    // A parked return drains first; no fetch is acted on in that cycle.
                    if (pend_valid_q) begin
                        inst_d       = pend_inst_q;
                        inst_pc_d    = pend_pc_q;
                        inst_valid_d = Enable;
                        pend_valid_d = Disable;
                    end else if (pc_enable_i && cache_hit) begin
                        inst_d       = cache_data;
                        inst_pc_d    = pc_i;
                        inst_valid_d = Enable;
                    end else if (pc_enable_i) begin
                        mem_req_d    = Enable;
                        mem_addr_d   = pc_i;
                        state_d      = WAIT_MEM;
                        inst_valid_d = Disable;
                    end else begin
                        inst_valid_d = Disable;
                    end
                end
            end
            WAIT_MEM: begin
                if (mem_done_i) begin
                    mem_req_d = Disable;
                    state_d   = IDLE;
                    discard_d = Disable;
                    if (deliver && stall_i) begin
                        pend_valid_d = Enable;
                        pend_inst_d  = mem_data_i;
                        pend_pc_d    = mem_addr_q;
                    end else if (deliver) begin
                        inst_d       = mem_data_i;
                        inst_pc_d    = mem_addr_q;
                        inst_valid_d = Enable;
                    end
                end else if (pc_jump_enable_i) begin
                    discard_d = Enable;
                end
                if (pc_jump_enable_i) begin
                    inst_valid_d = Disable;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            discard_q    <= Disable;
            mem_req_q    <= Disable;
            mem_addr_q   <= '0;
            inst_q       <= ZERO_WORD;
            inst_pc_q    <= '0;
            inst_valid_q <= Disable;
            pend_valid_q <= Disable;
            pend_inst_q  <= ZERO_WORD;
            pend_pc_q    <= '0;
        end else if (rdy) begin
            state_q      <= state_d;
            discard_q    <= discard_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_valid_q <= inst_valid_d;
            pend_valid_q <= pend_valid_d;
            pend_inst_q  <= pend_inst_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = inst_valid_q;

endmodule
